// File: rtl/enkel_pkg.sv
// ----------------------------------------------------------------------------
// enkel_pkg
// Shared definitions for the enkel fetch sequencer: the sequencer state
// enumeration and the default field widths of the datapath.
// No ports (package).
// ----------------------------------------------------------------------------
package enkel_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH_REQ = 3'd1,
        DECODE    = 3'd2,
        OPER_REQ  = 3'd3,
        HALT      = 3'd4
    } state_e;

    localparam int DEF_DATA_W = 8;  // memory word / IR width
    localparam int DEF_ADDR_W = 8;  // PC / MAR width
    localparam int DEF_OPC_W  = 3;  // opcode field width (IR MSBs)

endpackage

// File: rtl/fetch_sequencer_if.sv
// ----------------------------------------------------------------------------
// fetch_sequencer_if
// Single req/ack memory port between the fetch sequencer and memory.
// Signals:
//   mem_req   - request, held until mem_ack
//   mem_we    - write qualifier for the current request
//   mem_addr  - request address (MAR)
//   mem_wdata - write data, held with the request
//   mem_rdata - read data, valid with mem_ack
//   mem_ack   - one-cycle completion strobe
// Modports: master (sequencer side), slave (memory side).
// ----------------------------------------------------------------------------
interface fetch_sequencer_if
    import enkel_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/enkel_reg.sv
// ----------------------------------------------------------------------------
// enkel_reg
// Parametrised load-enable register with asynchronous active-low clear.
// Ports:
//   clk     - clock
//   reset_n - asynchronous active-low clear to RST_VAL
//   i_load  - load enable
//   i_d     - data in
//   o_q     - register contents
// ----------------------------------------------------------------------------
module enkel_reg #(
    parameter int             W       = 8,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_load,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_q;

    // NOTE: state is updated with <= so every register samples the values
    // from before the edge, independent of process evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q <= RST_VAL;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/fetch_sequencer.sv
// ----------------------------------------------------------------------------
// fetch_sequencer
// Instruction-fetch and operand-access sequencer for the enkel CPU datapath.
// Owns PC, IR, MAR and the show register, and talks to memory over one
// req/ack port with wait-state support, branch redirect, halt detection and
// page-mode operand addressing.
// Ports:
//   clk, reset_n        - clock, asynchronous active-low reset
//   i_run               - start/resume fetching from IDLE or HALT
//   mem                 - memory port (fetch_sequencer_if.master)
//   o_opcode, o_operand - IR fields
//   o_ir_valid          - high in DECODE
//   i_exec_done         - decoder finished the current instruction
//   i_op_access         - perform an operand access (sampled in DECODE)
//   i_op_write          - operand access is a write
//   i_op_wdata          - operand write data
//   o_op_rdata          - last operand read
//   o_op_rdata_valid    - one-cycle pulse when o_op_rdata updates
//   i_branch_take       - with i_exec_done: load i_branch_target into PC
//   i_branch_target     - branch target
//   i_show_load         - capture o_op_rdata into the show register
//   o_show_out          - show register
//   o_pc                - current PC
//   o_halted            - high in HALT
// ----------------------------------------------------------------------------
module fetch_sequencer
    import enkel_pkg::*;
#(
    parameter int                DATA_W    = DEF_DATA_W,
    parameter int                ADDR_W    = DEF_ADDR_W,
    parameter int                OPC_W     = DEF_OPC_W,
    parameter int                HALT_OPC  = 0,
    parameter int                PAGE_MODE = 1,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i_run,
    fetch_sequencer_if.master       mem,
    output logic [OPC_W-1:0]        o_opcode,
    output logic [DATA_W-OPC_W-1:0] o_operand,
    output logic                    o_ir_valid,
    input  logic                    i_exec_done,
    input  logic                    i_op_access,
    input  logic                    i_op_write,
    input  logic [DATA_W-1:0]       i_op_wdata,
    output logic [DATA_W-1:0]       o_op_rdata,
    output logic                    o_op_rdata_valid,
    input  logic                    i_branch_take,
    input  logic [ADDR_W-1:0]       i_branch_target,
    input  logic                    i_show_load,
    output logic [DATA_W-1:0]       o_show_out,
    output logic [ADDR_W-1:0]       o_pc,
    output logic                    o_halted
);
    localparam int OPND_W = DATA_W - OPC_W;

    state_e            r_state, w_next_state;
    logic [ADDR_W-1:0] w_pc_q, w_pc_d, w_mar_q, w_mar_d, w_oper_addr;
    logic [DATA_W-1:0] w_ir_q;
    logic              w_pc_load, w_mar_load, w_ir_load;
    logic              w_is_halt, w_oper_ack, w_decode_go;
    logic              r_op_write;
    logic [DATA_W-1:0] r_op_wdata, r_op_rdata;
    logic              r_op_rdata_valid;

    assign o_opcode    = w_ir_q[DATA_W-1 -: OPC_W];
    assign o_operand   = w_ir_q[OPND_W-1:0];
    assign w_is_halt   = (o_opcode == OPC_W'(HALT_OPC)) && !o_operand[0];
    assign w_decode_go = (r_state == DECODE) && !w_is_halt && i_exec_done;
    assign w_oper_ack  = (r_state == OPER_REQ) && mem.mem_ack;
    assign w_ir_load   = (r_state == FETCH_REQ) && mem.mem_ack;

    // Operand address: page mode places the operand in the address MSBs.
    generate
        if (PAGE_MODE != 0) begin : g_page
            if (OPND_W >= ADDR_W) begin : g_trunc
                assign w_oper_addr = o_operand[OPND_W-1 -: ADDR_W];
            end else begin : g_pad
                assign w_oper_addr = {o_operand, {(ADDR_W-OPND_W){1'b0}}};
            end
        end else begin : g_flat
            if (OPND_W >= ADDR_W) begin : g_trunc
                assign w_oper_addr = o_operand[ADDR_W-1:0];
            end else begin : g_pad
                assign w_oper_addr = {{(ADDR_W-OPND_W){1'b0}}, o_operand};
            end
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic. Halt detection has priority over exec_done.
    // NOTE: every variable written in an always_comb gets a default first,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:      if (i_run) w_next_state = FETCH_REQ;
            FETCH_REQ: if (mem.mem_ack) w_next_state = DECODE;
            DECODE: begin
                if (w_is_halt) begin
                    w_next_state = HALT;
                end else if (i_exec_done) begin
                    w_next_state = i_op_access ? OPER_REQ : FETCH_REQ;
                end
            end
            OPER_REQ:  if (mem.mem_ack) w_next_state = FETCH_REQ;
            HALT:      if (i_run) w_next_state = FETCH_REQ;
            default:   w_next_state = IDLE;
        endcase
    end

    // Outputs decoded from state alone, so an async reset drops mem_req
    // in the same instant it clears the state register.
    always_comb begin
        mem.mem_req = 1'b0;
        mem.mem_we  = 1'b0;
        o_ir_valid  = 1'b0;
        o_halted    = 1'b0;
        case (r_state)
            FETCH_REQ: mem.mem_req = 1'b1;
            OPER_REQ: begin
                mem.mem_req = 1'b1;
                mem.mem_we  = r_op_write;
            end
            DECODE:    o_ir_valid = 1'b1;
            HALT:      o_halted = 1'b1;
            default: ;
        endcase
    end

    assign mem.mem_addr  = w_mar_q;
    assign mem.mem_wdata = r_op_wdata;

    // PC / MAR load control. PC is incremented when the fetch completes,
    // so in DECODE it already holds the next sequential address; a taken
    // branch overwrites that increment.
    always_comb begin
        w_pc_load  = 1'b0;
        w_pc_d     = w_pc_q + ADDR_W'(1);
        w_mar_load = 1'b0;
        w_mar_d    = w_pc_q;
        case (r_state)
            IDLE, HALT: w_mar_load = i_run;
            FETCH_REQ:  w_pc_load  = mem.mem_ack;
            DECODE: begin
                if (w_decode_go) begin
                    w_pc_load  = i_branch_take;
                    w_pc_d     = i_branch_target;
                    w_mar_load = 1'b1;
                    if (i_op_access) begin
                        w_mar_d = w_oper_addr;
                    end else if (i_branch_take) begin
                        w_mar_d = i_branch_target;
                    end
                end
            end
            OPER_REQ:   w_mar_load = mem.mem_ack;
            default: ;
        endcase
    end

    // Operand access latches and read-back; the valid pulse lands in the
    // cycle where o_op_rdata first shows the new value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op_write       <= 1'b0;
            r_op_wdata       <= '0;
            r_op_rdata       <= '0;
            r_op_rdata_valid <= 1'b0;
        end else begin
            r_op_rdata_valid <= w_oper_ack && !r_op_write;
            if (w_decode_go && i_op_access) begin
                r_op_write <= i_op_write;
                r_op_wdata <= i_op_wdata;
            end
            if (w_oper_ack && !r_op_write) begin
                r_op_rdata <= mem.mem_rdata;
            end
        end
    end

    assign o_op_rdata       = r_op_rdata;
    assign o_op_rdata_valid = r_op_rdata_valid;
    assign o_pc             = w_pc_q;

    enkel_reg #(.W(ADDR_W), .RST_VAL(RESET_PC)) u_pc (
        .clk(clk), .reset_n(reset_n), .i_load(w_pc_load), .i_d(w_pc_d), .o_q(w_pc_q)
    );

    enkel_reg #(.W(DATA_W), .RST_VAL('0)) u_ir (
        .clk(clk), .reset_n(reset_n), .i_load(w_ir_load), .i_d(mem.mem_rdata), .o_q(w_ir_q)
    );

    enkel_reg #(.W(ADDR_W), .RST_VAL('0)) u_mar (
        .clk(clk), .reset_n(reset_n), .i_load(w_mar_load), .i_d(w_mar_d), .o_q(w_mar_q)
    );

    // Show captures the pre-edge op_rdata when both update together.
    enkel_reg #(.W(DATA_W), .RST_VAL('0)) u_show (
        .clk(clk), .reset_n(reset_n), .i_load(i_show_load), .i_d(r_op_rdata), .o_q(o_show_out)
    );
endmodule

// File: tb/tb_fetch_sequencer.sv
// ----------------------------------------------------------------------------
// tb_fetch_sequencer
// Self-checking bench for fetch_sequencer (DATA_W=8, ADDR_W=8, OPC_W=3,
// HALT_OPC=0, PAGE_MODE=1, RESET_PC=0). A behavioural memory answers
// requests with configurable wait states and logs every transaction; a
// transaction-level model predicts the expected transaction stream.
// ----------------------------------------------------------------------------
module tb_fetch_sequencer;

    typedef struct packed {
        logic [7:0] addr;
        logic       we;
        logic [7:0] wdata;
    } txn_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic       run, exec_done, op_access, op_write, branch_take, show_load;
    logic [7:0] op_wdata, branch_target;
    logic [2:0] opcode;
    logic [4:0] operand;
    logic       ir_valid, op_rdata_valid, halted;
    logic [7:0] op_rdata, show_out, pc;

    int total = 0;
    int bad   = 0;

    fetch_sequencer_if #(.ADDR_W(8), .DATA_W(8)) mem_bus ();

    fetch_sequencer #(
        .DATA_W(8), .ADDR_W(8), .OPC_W(3), .HALT_OPC(0), .PAGE_MODE(1), .RESET_PC(8'h00)
    ) dut (
        .clk(clk), .reset_n(reset_n), .i_run(run), .mem(mem_bus),
        .o_opcode(opcode), .o_operand(operand), .o_ir_valid(ir_valid),
        .i_exec_done(exec_done), .i_op_access(op_access), .i_op_write(op_write),
        .i_op_wdata(op_wdata), .o_op_rdata(op_rdata), .o_op_rdata_valid(op_rdata_valid),
        .i_branch_take(branch_take), .i_branch_target(branch_target),
        .i_show_load(show_load), .o_show_out(show_out), .o_pc(pc), .o_halted(halted)
    );

    // Behavioural memory: acks after wait_cfg idle request cycles.
    logic [7:0] mem_arr [256];
    txn_t       txn_log [$];
    int         wait_cfg = 0;
    int         wait_cnt = 0;
    bit         rand_wait = 1'b0;

    always @(negedge clk) begin
        txn_t t;
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = 8'h00;
        if (reset_n && mem_bus.mem_req === 1'b1) begin
            if (wait_cnt >= wait_cfg) begin
                mem_bus.mem_ack   = 1'b1;
                mem_bus.mem_rdata = mem_arr[mem_bus.mem_addr];
                t.addr  = mem_bus.mem_addr;
                t.we    = mem_bus.mem_we;
                t.wdata = mem_bus.mem_we ? mem_bus.mem_wdata : 8'h00;
                if (mem_bus.mem_we) mem_arr[mem_bus.mem_addr] = mem_bus.mem_wdata;
                txn_log.push_back(t);
                wait_cnt = 0;
                if (rand_wait) wait_cfg = int'($urandom_range(0, 2));
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        run = 0; exec_done = 0; op_access = 0; op_write = 0; op_wdata = 8'h00;
        branch_take = 0; branch_target = 8'h00; show_load = 0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_inputs();
        wait_cfg = 0; rand_wait = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic start_run();
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
    endtask

    task automatic wait_decode(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (ir_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        total++; if ({mem_bus.mem_req, mem_bus.mem_we, ir_valid, op_rdata_valid, halted} !== 5'b0) begin
            bad++; $display("FAIL reset_strobes: got %b want 00000",
                {mem_bus.mem_req, mem_bus.mem_we, ir_valid, op_rdata_valid, halted});
        end
        total++; if (pc !== 8'h00) begin bad++; $display("FAIL reset_pc: got %h want 00", pc); end
        total++; if (mem_bus.mem_addr !== 8'h00) begin bad++; $display("FAIL reset_mar: got %h want 00", mem_bus.mem_addr); end
        total++; if ({opcode, operand} !== 8'h00) begin bad++; $display("FAIL reset_ir: got %h want 00", {opcode, operand}); end
        total++; if ({op_rdata, show_out} !== 16'h0) begin bad++; $display("FAIL reset_data: got %h want 0000", {op_rdata, show_out}); end
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (mem_bus.mem_req !== 1'b0) begin bad++; $display("FAIL idle_no_req: got %b want 0", mem_bus.mem_req); end
    endtask

    task automatic test_first_fetch();
        do_reset();
        mem_arr[0] = 8'h25;
        start_run();
        total++; if ({mem_bus.mem_req, mem_bus.mem_addr} !== {1'b1, 8'h00}) begin
            bad++; $display("FAIL first_req: got req=%b addr=%h want req=1 addr=00", mem_bus.mem_req, mem_bus.mem_addr);
        end
        @(negedge clk);
        total++; if ({ir_valid, opcode, operand, pc} !== {1'b1, 3'd1, 5'd5, 8'h01}) begin
            bad++; $display("FAIL first_decode: got v=%b opc=%0d opnd=%0d pc=%h want v=1 opc=1 opnd=5 pc=01",
                ir_valid, opcode, operand, pc);
        end
    endtask

    task automatic test_wait_states();
        int req_cycles = 0;
        int addr_bad = 0;
        int ir_early = 0;
        do_reset();
        mem_arr[0] = 8'h47;
        wait_cfg = 3;
        start_run();
        for (int i = 0; i < 10; i++) begin
            if (mem_bus.mem_req === 1'b1) begin
                req_cycles++;
                if (mem_bus.mem_addr !== 8'h00) addr_bad++;
                if (ir_valid !== 1'b0 || {opcode, operand} !== 8'h00) ir_early++;
            end
            @(negedge clk);
        end
        wait_cfg = 0;
        total++; if (req_cycles != 4) begin bad++; $display("FAIL wait_req_len: got %0d want 4", req_cycles); end
        total++; if (addr_bad != 0 || ir_early != 0) begin
            bad++; $display("FAIL wait_stable: got addr_changes=%0d ir_early=%0d want 0 0", addr_bad, ir_early);
        end
        total++; if ({ir_valid, opcode, operand} !== {1'b1, 8'h47}) begin
            bad++; $display("FAIL wait_ir: got v=%b ir=%h want v=1 ir=47", ir_valid, {opcode, operand});
        end
    endtask

    task automatic test_branch_wrap();
        bit ok;
        do_reset();
        mem_arr[0] = 8'h25; mem_arr[8'hF0] = 8'h21; mem_arr[8'hFF] = 8'h33; mem_arr[8'h40] = 8'h21;
        start_run();
        wait_decode(ok);
        total++; if (!ok) begin bad++; $display("FAIL br_decode0: got timeout want decode"); end
        exec_done = 1; branch_take = 1; branch_target = 8'hF0;
        @(negedge clk);
        clear_inputs();
        total++; if (mem_bus.mem_addr !== 8'hF0) begin bad++; $display("FAIL br_target_addr: got %h want f0", mem_bus.mem_addr); end
        @(negedge clk);
        total++; if ({pc, opcode, operand} !== {8'hF1, 8'h21}) begin
            bad++; $display("FAIL br_pc: got pc=%h ir=%h want pc=f1 ir=21", pc, {opcode, operand});
        end
        exec_done = 1; branch_take = 1; branch_target = 8'hFF;
        @(negedge clk);
        clear_inputs();
        total++; if (mem_bus.mem_addr !== 8'hFF) begin bad++; $display("FAIL br_ff_addr: got %h want ff", mem_bus.mem_addr); end
        @(negedge clk);
        total++; if ({pc, opcode, operand} !== {8'h00, 8'h33}) begin
            bad++; $display("FAIL pc_wrap: got pc=%h ir=%h want pc=00 ir=33", pc, {opcode, operand});
        end
        // Branch together with an operand access: operand first, then target.
        exec_done = 1; op_access = 1; branch_take = 1; branch_target = 8'h40;
        @(negedge clk);
        clear_inputs();
        total++; if (mem_bus.mem_addr !== 8'h98) begin bad++; $display("FAIL br_oper_addr: got %h want 98", mem_bus.mem_addr); end
        @(negedge clk);
        total++; if ({mem_bus.mem_req, mem_bus.mem_addr, pc} !== {1'b1, 8'h40, 8'h40}) begin
            bad++; $display("FAIL br_after_oper: got req=%b addr=%h pc=%h want req=1 addr=40 pc=40",
                mem_bus.mem_req, mem_bus.mem_addr, pc);
        end
    endtask

    task automatic test_operand();
        bit ok;
        int pulses = 0;
        logic [7:0] v = 8'($urandom);
        logic [7:0] w = 8'($urandom);
        do_reset();
        mem_arr[0] = 8'h2B; mem_arr[1] = 8'h2B; mem_arr[8'h58] = v;
        start_run();
        wait_decode(ok);
        exec_done = 1; op_access = 1; op_write = 0;
        @(negedge clk);
        clear_inputs();
        total++; if ({mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_addr} !== {2'b10, 8'h58}) begin
            bad++; $display("FAIL oper_rd_req: got req=%b we=%b addr=%h want req=1 we=0 addr=58",
                mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_addr);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (op_rdata_valid === 1'b1) pulses++;
            if (i == 0) begin
                total++; if ({op_rdata, mem_bus.mem_addr} !== {v, 8'h01}) begin
                    bad++; $display("FAIL oper_rdata: got data=%h addr=%h want data=%h addr=01", op_rdata, mem_bus.mem_addr, v);
                end
            end
        end
        total++; if (pulses != 1) begin bad++; $display("FAIL oper_valid_pulse: got %0d want 1", pulses); end
        exec_done = 1; op_access = 1; op_write = 1; op_wdata = w;
        @(negedge clk);
        clear_inputs();
        op_wdata = ~w;
        total++; if ({mem_bus.mem_we, mem_bus.mem_wdata, mem_bus.mem_addr} !== {1'b1, w, 8'h58}) begin
            bad++; $display("FAIL oper_wr_req: got we=%b wdata=%h addr=%h want we=1 wdata=%h addr=58",
                mem_bus.mem_we, mem_bus.mem_wdata, mem_bus.mem_addr, w);
        end
        @(negedge clk);
        total++; if ({mem_arr[8'h58], op_rdata, op_rdata_valid} !== {w, v, 1'b0}) begin
            bad++; $display("FAIL oper_wr_done: got mem=%h rdata=%h valid=%b want mem=%h rdata=%h valid=0",
                mem_arr[8'h58], op_rdata, op_rdata_valid, w, v);
        end
    endtask

    task automatic test_show();
        bit ok;
        logic [7:0] v1 = 8'($urandom);
        logic [7:0] v2;
        v2 = v1 ^ 8'h5A;
        do_reset();
        mem_arr[0] = 8'h29; mem_arr[1] = 8'h2A; mem_arr[8'h48] = v1; mem_arr[8'h50] = v2;
        start_run();
        wait_decode(ok);
        exec_done = 1; op_access = 1;
        @(negedge clk);
        clear_inputs();
        wait_decode(ok);
        exec_done = 1; op_access = 1;
        @(negedge clk);
        clear_inputs();
        show_load = 1;
        @(negedge clk);
        show_load = 0;
        total++; if ({show_out, op_rdata} !== {v1, v2}) begin
            bad++; $display("FAIL show_old: got show=%h rdata=%h want show=%h rdata=%h", show_out, op_rdata, v1, v2);
        end
        show_load = 1;
        @(negedge clk);
        show_load = 0;
        total++; if (show_out !== v2) begin bad++; $display("FAIL show_new: got %h want %h", show_out, v2); end
    endtask

    task automatic test_halt();
        bit ok;
        int req_seen = 0;
        do_reset();
        mem_arr[0] = 8'h01; mem_arr[1] = 8'h00; mem_arr[2] = 8'h25;
        start_run();
        wait_decode(ok);
        repeat (3) @(negedge clk);
        total++; if ({halted, ir_valid} !== 2'b01) begin
            bad++; $display("FAIL no_halt_odd: got halted=%b ir_valid=%b want 0 1", halted, ir_valid);
        end
        exec_done = 1;
        @(negedge clk);
        exec_done = 0;
        wait_decode(ok);
        @(negedge clk);
        total++; if ({halted, pc} !== {1'b1, 8'h02}) begin
            bad++; $display("FAIL halt_enter: got halted=%b pc=%h want 1 02", halted, pc);
        end
        exec_done = 1;
        for (int i = 0; i < 5; i++) begin
            if (mem_bus.mem_req !== 1'b0) req_seen++;
            @(negedge clk);
        end
        exec_done = 0;
        total++; if (req_seen != 0 || halted !== 1'b1) begin
            bad++; $display("FAIL halt_quiet: got reqs=%0d halted=%b want 0 1", req_seen, halted);
        end
        start_run();
        total++; if ({mem_bus.mem_req, mem_bus.mem_addr, halted} !== {1'b1, 8'h02, 1'b0}) begin
            bad++; $display("FAIL halt_resume: got req=%b addr=%h halted=%b want 1 02 0",
                mem_bus.mem_req, mem_bus.mem_addr, halted);
        end
        wait_decode(ok);
        total++; if ({opcode, operand, pc} !== {8'h25, 8'h03}) begin
            bad++; $display("FAIL halt_refetch: got ir=%h pc=%h want 25 03", {opcode, operand}, pc);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int req_seen = 0;
        do_reset();
        mem_arr[0] = 8'h2B; mem_arr[8'h58] = 8'hC3;
        start_run();
        wait_decode(ok);
        wait_cfg = 6;
        exec_done = 1; op_access = 1;
        @(negedge clk);
        clear_inputs();
        total++; if (mem_bus.mem_req !== 1'b1) begin bad++; $display("FAIL mid_in_oper: got %b want 1", mem_bus.mem_req); end
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        total++; if ({mem_bus.mem_req, ir_valid, pc, mem_bus.mem_addr, opcode, operand} !== 26'h0) begin
            bad++; $display("FAIL mid_reset_clear: got req=%b v=%b pc=%h addr=%h ir=%h want all 0",
                mem_bus.mem_req, ir_valid, pc, mem_bus.mem_addr, {opcode, operand});
        end
        @(negedge clk);
        reset_n = 1'b1;
        wait_cfg = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (mem_bus.mem_req !== 1'b0 || op_rdata_valid !== 1'b0) req_seen++;
        end
        total++; if (req_seen != 0 || op_rdata !== 8'h00) begin
            bad++; $display("FAIL mid_idle: got activity=%0d rdata=%h want 0 00", req_seen, op_rdata);
        end
        start_run();
        total++; if ({mem_bus.mem_req, mem_bus.mem_addr} !== {1'b1, 8'h00}) begin
            bad++; $display("FAIL mid_restart: got req=%b addr=%h want 1 00", mem_bus.mem_req, mem_bus.mem_addr);
        end
    endtask

    // Random program: architectural model predicts every memory transaction,
    // each decoded instruction, PC and last operand read.
    task automatic test_random();
        logic [7:0] ref_mem [256];
        txn_t       exp_q [$];
        txn_t       t;
        logic [7:0] ref_pc = 8'h00;
        logic [7:0] ref_rdata = 8'h00;
        logic [7:0] ir, a, wd, tgt;
        bit         ok, acc, wr, br;
        do_reset();
        for (int i = 0; i < 256; i++) begin
            mem_arr[i] = 8'($urandom);
            ref_mem[i] = mem_arr[i];
        end
        txn_log.delete();
        rand_wait = 1'b1;
        start_run();
        for (int k = 0; k < 150; k++) begin
            t.addr = ref_pc; t.we = 1'b0; t.wdata = 8'h00;
            exp_q.push_back(t);
            ir = ref_mem[ref_pc];
            ref_pc = ref_pc + 8'd1;
            wait_decode(ok);
            total++; if (!ok) begin bad++; $display("FAIL rnd_timeout: instr %0d got no decode want decode", k); break; end
            total++; if ({opcode, operand, pc, op_rdata} !== {ir, ref_pc, ref_rdata}) begin
                bad++; $display("FAIL rnd_decode: instr %0d got ir=%h pc=%h rdata=%h want ir=%h pc=%h rdata=%h",
                    k, {opcode, operand}, pc, op_rdata, ir, ref_pc, ref_rdata);
            end
            if (ir[7:5] == 3'd0 && ir[0] == 1'b0) begin
                @(negedge clk);
                total++; if (halted !== 1'b1) begin bad++; $display("FAIL rnd_halt: instr %0d got %b want 1", k, halted); end
                start_run();
                continue;
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            acc = 1'($urandom); wr = 1'($urandom); br = ($urandom_range(0, 3) == 0);
            wd = 8'($urandom); tgt = 8'($urandom);
            exec_done = 1; op_access = acc; op_write = wr; op_wdata = wd;
            branch_take = br; branch_target = tgt;
            @(negedge clk);
            clear_inputs();
            if (br) ref_pc = tgt;
            if (acc) begin
                a = {ir[4:0], 3'b000};
                t.addr = a; t.we = wr; t.wdata = wr ? wd : 8'h00;
                exp_q.push_back(t);
                if (wr) ref_mem[a] = wd;
                else    ref_rdata = ref_mem[a];
            end
        end
        repeat (3) @(negedge clk);
        rand_wait = 1'b0;
        total++; if (txn_log.size() < exp_q.size()) begin
            bad++; $display("FAIL rnd_txn_count: got %0d want >= %0d", txn_log.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < txn_log.size(); i++) begin
            total++; if (txn_log[i] !== exp_q[i]) begin
                bad++; $display("FAIL rnd_txn[%0d]: got addr=%h we=%b wd=%h want addr=%h we=%b wd=%h", i,
                    txn_log[i].addr, txn_log[i].we, txn_log[i].wdata, exp_q[i].addr, exp_q[i].we, exp_q[i].wdata);
            end
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_first_fetch();
        test_wait_states();
        test_branch_wrap();
        test_operand();
        test_show();
        test_halt();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
